// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the shared-memory multicycle MIPS datapath: sequences
// fetch/decode/execute/memory/writeback, traps illegal opcodes and counts retirements.
module multicycle_ctrl #(
  parameter int OP_W          = 6,
  parameter int ALU_OP_W      = 3,
  parameter int CNT_W         = 32,
  parameter int MEM_HANDSHAKE = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [OP_W-1:0]     instr_op_i,
  input  logic                mem_ready_i,
  output logic                PCWrite_o,
  output logic                PCWriteCond_o,
  output logic                IorD_o,
  output logic                MemRead_o,
  output logic                MemWrite_o,
  output logic                IRWrite_o,
  output logic                MemtoReg_o,
  output logic                RegWrite_o,
  output logic                RegDst_o,
  output logic                ALUSrcA_o,
  output logic [1:0]          ALUSrcB_o,
  output logic [ALU_OP_W-1:0] ALU_op_o,
  output logic [1:0]          PCSource_o,
  output logic                illegal_o,
  output logic [3:0]          state_o,
  output logic [CNT_W-1:0]    instr_count_o
);

  typedef enum logic [3:0] {
    S_IF     = 4'd0,
    S_ID     = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXR    = 4'd6,
    S_WBR    = 4'd7,
    S_EXI    = 4'd8,
    S_WBI    = 4'd9,
    S_BR     = 4'd10,
    S_JMP    = 4'd11,
    S_TRAP   = 4'd15
  } state_e;

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(6'b001010);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);

  localparam logic [ALU_OP_W-1:0] ALU_ADD   = ALU_OP_W'(3'b000);
  localparam logic [ALU_OP_W-1:0] ALU_SUB   = ALU_OP_W'(3'b001);
  localparam logic [ALU_OP_W-1:0] ALU_FUNCT = ALU_OP_W'(3'b010);
  localparam logic [ALU_OP_W-1:0] ALU_SLT   = ALU_OP_W'(3'b011);

  state_e            state_q, state_d;
  logic [OP_W-1:0]   op_q;
  logic              illegal_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              ready;
  logic              retire;
  logic              pcw, pcwc, mrd, mwr, irw, rgw;

  assign ready = mem_ready_i | (MEM_HANDSHAKE == 0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IF;
      op_q      <= '0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_ID) op_q <= instr_op_i;
      if (state_d == S_TRAP) illegal_q <= 1'b1;
      if (retire) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Next state and Moore outputs; only IF's IRWrite/PCWrite look at mem_ready_i.
  always_comb begin
    state_d       = state_q;
    retire        = 1'b0;
    pcw           = 1'b0;
    pcwc          = 1'b0;
    mrd           = 1'b0;
    mwr           = 1'b0;
    irw           = 1'b0;
    rgw           = 1'b0;
    IorD_o        = 1'b0;
    MemtoReg_o    = 1'b0;
    RegDst_o      = 1'b0;
    ALUSrcA_o     = 1'b0;
    ALUSrcB_o     = 2'b00;
    ALU_op_o      = ALU_ADD;
    PCSource_o    = 2'b00;
    unique case (state_q)
      S_IF: begin
        mrd       = 1'b1;
        ALUSrcB_o = 2'b01;
        irw       = ready;
        pcw       = ready;
        if (ready) state_d = S_ID;
      end
      S_ID: begin
        ALUSrcB_o = 2'b11;
        if (instr_op_i == OP_RTYPE)                          state_d = S_EXR;
        else if (instr_op_i == OP_ADDI || instr_op_i == OP_SLTI) state_d = S_EXI;
        else if (instr_op_i == OP_BEQ)                       state_d = S_BR;
        else if (instr_op_i == OP_LW || instr_op_i == OP_SW) state_d = S_MEMADR;
        else if (instr_op_i == OP_J)                         state_d = S_JMP;
        else                                                 state_d = S_TRAP;
      end
      S_MEMADR: begin
        ALUSrcA_o = 1'b1;
        ALUSrcB_o = 2'b10;
        state_d   = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mrd    = 1'b1;
        IorD_o = 1'b1;
        if (ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        rgw        = 1'b1;
        MemtoReg_o = 1'b1;
        retire     = 1'b1;
        state_d    = S_IF;
      end
      S_MEMWR: begin
        mwr    = 1'b1;
        IorD_o = 1'b1;
        if (ready) begin
          retire  = 1'b1;
          state_d = S_IF;
        end
      end
      S_EXR: begin
        ALUSrcA_o = 1'b1;
        ALU_op_o  = ALU_FUNCT;
        state_d   = S_WBR;
      end
      S_WBR: begin
        RegDst_o = 1'b1;
        rgw      = 1'b1;
        retire   = 1'b1;
        state_d  = S_IF;
      end
      S_EXI: begin
        ALUSrcA_o = 1'b1;
        ALUSrcB_o = 2'b10;
        ALU_op_o  = (op_q == OP_SLTI) ? ALU_SLT : ALU_ADD;
        state_d   = S_WBI;
      end
      S_WBI: begin
        rgw     = 1'b1;
        retire  = 1'b1;
        state_d = S_IF;
      end
      S_BR: begin
        ALUSrcA_o  = 1'b1;
        ALU_op_o   = ALU_SUB;
        pcwc       = 1'b1;
        PCSource_o = 2'b01;
        retire     = 1'b1;
        state_d    = S_IF;
      end
      S_JMP: begin
        pcw        = 1'b1;
        PCSource_o = 2'b10;
        retire     = 1'b1;
        state_d    = S_IF;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
    if (rst_i) retire = 1'b0;
  end

  // Reset suppresses every write/request so an abandoned instruction leaves no trace.
  assign PCWrite_o     = pcw  & ~rst_i;
  assign PCWriteCond_o = pcwc & ~rst_i;
  assign MemRead_o     = mrd  & ~rst_i;
  assign MemWrite_o    = mwr  & ~rst_i;
  assign IRWrite_o     = irw  & ~rst_i;
  assign RegWrite_o    = rgw  & ~rst_i;

  assign illegal_o     = illegal_q;
  assign state_o       = state_q;
  assign instr_count_o = cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomised bench: builds each instruction's expected state walk from its class and
// wait counts, and checks two DUT instances (32-bit and 4-bit counters) every cycle.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [5:0]  instr_op_i;
  logic        mem_ready_i;

  logic        pcw_a, pcwc_a, iord_a, mrd_a, mwr_a, irw_a, m2r_a, rgw_a, rdst_a, srca_a;
  logic [1:0]  srcb_a, pcs_a;
  logic [2:0]  alu_a;
  logic        ill_a;
  logic [3:0]  st_a;
  logic [31:0] cnt_a;

  logic        pcw_b, pcwc_b, iord_b, mrd_b, mwr_b, irw_b, m2r_b, rgw_b, rdst_b, srca_b;
  logic [1:0]  srcb_b, pcs_b;
  logic [2:0]  alu_b;
  logic        ill_b;
  logic [3:0]  st_b;
  logic [3:0]  cnt_b;

  always #5 clk = ~clk;

  multicycle_ctrl dut_a (
    .clk_i(clk), .rst_i(rst_i), .instr_op_i(instr_op_i), .mem_ready_i(mem_ready_i),
    .PCWrite_o(pcw_a), .PCWriteCond_o(pcwc_a), .IorD_o(iord_a), .MemRead_o(mrd_a),
    .MemWrite_o(mwr_a), .IRWrite_o(irw_a), .MemtoReg_o(m2r_a), .RegWrite_o(rgw_a),
    .RegDst_o(rdst_a), .ALUSrcA_o(srca_a), .ALUSrcB_o(srcb_a), .ALU_op_o(alu_a),
    .PCSource_o(pcs_a), .illegal_o(ill_a), .state_o(st_a), .instr_count_o(cnt_a)
  );

  multicycle_ctrl #(.CNT_W(4)) dut_b (
    .clk_i(clk), .rst_i(rst_i), .instr_op_i(instr_op_i), .mem_ready_i(mem_ready_i),
    .PCWrite_o(pcw_b), .PCWriteCond_o(pcwc_b), .IorD_o(iord_b), .MemRead_o(mrd_b),
    .MemWrite_o(mwr_b), .IRWrite_o(irw_b), .MemtoReg_o(m2r_b), .RegWrite_o(rgw_b),
    .RegDst_o(rdst_b), .ALUSrcA_o(srca_b), .ALUSrcB_o(srcb_b), .ALU_op_o(alu_b),
    .PCSource_o(pcs_b), .illegal_o(ill_b), .state_o(st_b), .instr_count_o(cnt_b)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic        e_valid  = 1'b0;
  int          e_state;
  logic        e_rdy, e_rst;
  logic [5:0]  cur_op;
  logic [31:0] m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Expected control word {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,
  // MemtoReg,RegWrite,RegDst,ALUSrcA,ALUSrcB,ALU_op,PCSource} straight from the state table.
  function automatic logic [16:0] exp_ctrl(input int st, input logic [5:0] op,
                                           input logic rdy, input logic rst);
    logic pw, pwc, iod, mr, mw, irw, m2r, rw, rd, sa;
    logic [1:0] sb, ps;
    logic [2:0] al;
    {pw, pwc, iod, mr, mw, irw, m2r, rw, rd, sa} = '0;
    sb = 2'b00; ps = 2'b00; al = 3'b000;
    case (st)
      0:  begin mr = 1; sb = 2'b01; irw = rdy; pw = rdy; end
      1:  sb = 2'b11;
      2:  begin sa = 1; sb = 2'b10; end
      3:  begin mr = 1; iod = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mw = 1; iod = 1; end
      6:  begin sa = 1; al = 3'b010; end
      7:  begin rd = 1; rw = 1; end
      8:  begin sa = 1; sb = 2'b10; al = (op == 6'b001010) ? 3'b011 : 3'b000; end
      9:  rw = 1;
      10: begin sa = 1; al = 3'b001; pwc = 1; ps = 2'b01; end
      11: begin pw = 1; ps = 2'b10; end
      default: ;
    endcase
    if (rst) {pw, pwc, mr, mw, irw, rw} = '0;
    return {pw, pwc, iod, mr, mw, irw, m2r, rw, rd, sa, sb, al, ps};
  endfunction

  always @(negedge clk) begin
    if (e_valid) begin
      logic [16:0] exp_c;
      exp_c = exp_ctrl(e_state, cur_op, e_rdy, e_rst);
      chk("state_a", 32'(st_a), 32'(e_state));
      chk("ctrl_a", 32'({pw_a_w(), iord_a, mrd_a, mwr_a, irw_a, m2r_a, rgw_a, rdst_a,
                         srca_a, srcb_a, alu_a, pcs_a}), 32'(exp_c));
      chk("illegal_a", 32'(ill_a), 32'(e_state == 15));
      chk("count_a", cnt_a, m_cnt);
      chk("state_b", 32'(st_b), 32'(e_state));
      chk("ctrl_b", 32'({pcw_b, pcwc_b, iord_b, mrd_b, mwr_b, irw_b, m2r_b, rgw_b, rdst_b,
                         srca_b, srcb_b, alu_b, pcs_b}), 32'(exp_c));
      chk("count_b", 32'(cnt_b), 32'(m_cnt[3:0]));
    end
  end

  function automatic logic [1:0] pw_a_w();
    return {pcw_a, pcwc_a};
  endfunction

  // One clock cycle in which the DUT is expected to sit in state st.
  task automatic cycle(input int st, input logic rdy, input logic rst, input logic ret);
    mem_ready_i = rdy;
    rst_i       = rst;
    instr_op_i  = (st == 1) ? cur_op : 6'($urandom);
    e_state     = st;
    e_rdy       = rdy;
    e_rst       = rst;
    e_valid     = 1'b1;
    @(posedge clk);
    #1;
    if (rst) m_cnt = 0;
    else if (ret) m_cnt = m_cnt + 1;
  endtask

  function automatic logic legal(input logic [5:0] op);
    return op inside {6'b000000, 6'b001000, 6'b001010, 6'b000100,
                      6'b100011, 6'b101011, 6'b000010};
  endfunction

  task automatic run_instr(input logic [5:0] op, input int wif, input int wmem,
                           input int ntrap);
    cur_op = op;
    repeat (wif) cycle(0, 1'b0, 1'b0, 1'b0);
    cycle(0, 1'b1, 1'b0, 1'b0);
    cycle(1, 1'($urandom), 1'b0, 1'b0);
    case (op)
      6'b000000: begin cycle(6, 1'($urandom), 0, 0); cycle(7, 1'($urandom), 0, 1); end
      6'b001000,
      6'b001010: begin cycle(8, 1'($urandom), 0, 0); cycle(9, 1'($urandom), 0, 1); end
      6'b000100: cycle(10, 1'($urandom), 0, 1);
      6'b000010: cycle(11, 1'($urandom), 0, 1);
      6'b100011: begin
        cycle(2, 1'($urandom), 0, 0);
        repeat (wmem) cycle(3, 1'b0, 0, 0);
        cycle(3, 1'b1, 0, 0);
        cycle(4, 1'($urandom), 0, 1);
      end
      6'b101011: begin
        cycle(2, 1'($urandom), 0, 0);
        repeat (wmem) cycle(5, 1'b0, 0, 0);
        cycle(5, 1'b1, 0, 1);
      end
      default: begin
        repeat (ntrap) cycle(15, 1'($urandom), 0, 0);
        cycle(15, 1'($urandom), 1'b1, 1'b0);
      end
    endcase
  endtask

  initial begin
    logic [5:0] op;
    int         k;
    rst_i       = 1'b1;
    mem_ready_i = 1'b1;
    instr_op_i  = 6'd0;
    cur_op      = 6'd0;
    m_cnt       = 0;
    @(posedge clk);
    #1;
    cycle(0, 1'b1, 1'b1, 1'b0);

    run_instr(6'b000000, 0, 0, 0);
    chk("rtype_count_lit", cnt_a, 32'd1);
    run_instr(6'b100011, 0, 2, 0);
    chk("lw_count_lit", cnt_a, 32'd2);
    run_instr(6'b001010, 0, 0, 0);
    run_instr(6'b000100, 0, 0, 0);
    chk("slti_beq_count_lit", cnt_a, 32'd4);

    cur_op = 6'b101011;
    cycle(0, 1'b1, 0, 0);
    cycle(1, 1'b1, 0, 0);
    cycle(2, 1'b1, 0, 0);
    cycle(5, 1'b0, 0, 0);
    cycle(5, 1'b0, 1'b1, 0);
    chk("rst_in_memwr_count_lit", cnt_a, 32'd0);
    chk("rst_in_memwr_state_lit", 32'(st_a), 32'd0);

    for (int i = 0; i < 16; i++) run_instr(6'b000010, 0, 0, 0);
    chk("j16_wrap_small_lit", 32'(cnt_b), 32'd0);
    chk("j16_count_big_lit", cnt_a, 32'd16);

    run_instr(6'b111111, 0, 0, 10);
    chk("trap_reset_illegal_lit", 32'(ill_a), 32'd0);
    chk("trap_reset_state_lit", 32'(st_a), 32'd0);

    for (int i = 0; i < 300; i++) begin
      k = int'($urandom_range(0, 15));
      case (k)
        0, 1:   op = 6'b000000;
        2:      op = 6'b001000;
        3, 4:   op = 6'b001010;
        5, 6:   op = 6'b000100;
        7, 8:   op = 6'b100011;
        9, 10:  op = 6'b101011;
        11, 12: op = 6'b000010;
        default: begin
          op = 6'($urandom);
          if (legal(op) || k < 15) op = 6'b000000;
        end
      endcase
      if (k == 15 && !legal(op)) op = 6'($urandom) | 6'b110000;
      if (k == 15 && legal(op)) op = 6'b111111;
      run_instr(op,
                ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3)),
                ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3)),
                int'($urandom_range(1, 4)));
    end

    e_valid = 1'b0;
    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
